// File: rtl/ex_issue_unit.sv
// ex_issue_unit
// Decode/issue stage of the 4-stage 8-bit pipeline (fetch, decode/issue,
// execute, writeback). Decodes one instruction per accept, resolves its
// source operands with EX forwarding and WB bypass, and holds the decoded
// op in a registered ID/EX stage that drives the ALU interface.
//
// Ports:
//   clk, rst_n           rising-edge clock, asynchronous active-low reset
//   instr_valid/instr    instruction from fetch ([7:6] op, [5:4] rd,
//                        [3:2] rs, [3:0] imm4)
//   instr_ready          instruction accepted this cycle when high
//   wb_en/wb_addr/wb_data writeback port into the register file
//   alu_result           current ALU output, used as the EX forwarding source
//   ex_ready             execute stage consumes the issued op this cycle
//   ex_valid             issued op valid
//   alu_ctrl             ALU operation (11 = ADD, 01 = SLL)
//   inp1, inp2           ALU operands
//   ex_rd, ex_wb_en      destination and write-enable of the issued op
//   issue_cnt            number of issued non-NOP ops, wraps at 8 bits
module ex_issue_unit #(
    parameter int DATA_W = 8,
    parameter int REGS   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    input  logic [7:0]        instr,
    output logic              instr_ready,
    input  logic              wb_en,
    input  logic [1:0]        wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              ex_ready,
    output logic              ex_valid,
    output logic [1:0]        alu_ctrl,
    output logic [DATA_W-1:0] inp1,
    output logic [DATA_W-1:0] inp2,
    output logic [1:0]        ex_rd,
    output logic              ex_wb_en,
    output logic [7:0]        issue_cnt
);

    typedef enum logic [1:0] {
        OP_NOP  = 2'b00,
        OP_SLL  = 2'b01,
        OP_MOVI = 2'b10,
        OP_ADD  = 2'b11
    } op_e;

    localparam logic [1:0] ALU_ADD = 2'b11;
    localparam logic [1:0] ALU_SLL = 2'b01;

    logic [DATA_W-1:0] regs_q [REGS];

    logic              ex_valid_q,  ex_valid_d;
    logic [1:0]        alu_ctrl_q,  alu_ctrl_d;
    logic [DATA_W-1:0] inp1_q,      inp1_d;
    logic [DATA_W-1:0] inp2_q,      inp2_d;
    logic [1:0]        ex_rd_q,     ex_rd_d;
    logic              ex_wb_en_q,  ex_wb_en_d;
    logic [7:0]        issue_cnt_q, issue_cnt_d;

    op_e               opcode;
    logic [1:0]        rdField;
    logic [1:0]        rsField;
    logic [3:0]        imm4;
    logic              accept;
    logic [DATA_W-1:0] opA;
    logic [DATA_W-1:0] opB;

    assign opcode  = op_e'(instr[7:6]);
    assign rdField = instr[5:4];
    assign rsField = instr[3:2];
    assign imm4    = instr[3:0];

    // A stalled op blocks fetch; an empty or draining stage can take a new one.
    assign instr_ready = !ex_valid_q || ex_ready;
    assign accept      = instr_valid && instr_ready;

    // Operand resolution: the op sitting in EX is newer than anything in
    // writeback, so it is applied last and overrides the WB bypass.
    always_comb begin
        opA = regs_q[rdField];
        opB = regs_q[rsField];
        if (wb_en && (wb_addr == rdField)) begin
            opA = wb_data;
        end
        if (wb_en && (wb_addr == rsField)) begin
            opB = wb_data;
        end
        if (ex_valid_q && ex_wb_en_q && (ex_rd_q == rdField)) begin
            opA = alu_result;
        end
        if (ex_valid_q && ex_wb_en_q && (ex_rd_q == rsField)) begin
            opB = alu_result;
        end
    end

    // ID/EX next state. Without an accept the stage either holds (stall)
    // or empties once execute has taken the op. A NOP is consumed as a
    // bubble and leaves the payload registers untouched.
    always_comb begin
        ex_valid_d  = ex_valid_q;
        alu_ctrl_d  = alu_ctrl_q;
        inp1_d      = inp1_q;
        inp2_d      = inp2_q;
        ex_rd_d     = ex_rd_q;
        ex_wb_en_d  = ex_wb_en_q;
        issue_cnt_d = issue_cnt_q;
        if (accept) begin
            case (opcode)
                OP_ADD, OP_SLL: begin
                    ex_valid_d  = 1'b1;
                    alu_ctrl_d  = (opcode == OP_ADD) ? ALU_ADD : ALU_SLL;
                    inp1_d      = opA;
                    inp2_d      = opB;
                    ex_rd_d     = rdField;
                    ex_wb_en_d  = 1'b1;
                    issue_cnt_d = issue_cnt_q + 8'd1;
                end
                OP_MOVI: begin
                    ex_valid_d  = 1'b1;
                    alu_ctrl_d  = ALU_ADD;
                    inp1_d      = '0;
                    inp2_d      = {{(DATA_W-4){1'b0}}, imm4};
                    ex_rd_d     = rdField;
                    ex_wb_en_d  = 1'b1;
                    issue_cnt_d = issue_cnt_q + 8'd1;
                end
                default: begin
                    ex_valid_d = 1'b0;
                    ex_wb_en_d = 1'b0;
                end
            endcase
        end else if (ex_ready) begin
            ex_valid_d = 1'b0;
        end
    end

    // ID/EX stage register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q  <= 1'b0;
            alu_ctrl_q  <= 2'b00;
            inp1_q      <= '0;
            inp2_q      <= '0;
            ex_rd_q     <= 2'b00;
            ex_wb_en_q  <= 1'b0;
            issue_cnt_q <= 8'd0;
        end else begin
            ex_valid_q  <= ex_valid_d;
            alu_ctrl_q  <= alu_ctrl_d;
            inp1_q      <= inp1_d;
            inp2_q      <= inp2_d;
            ex_rd_q     <= ex_rd_d;
            ex_wb_en_q  <= ex_wb_en_d;
            issue_cnt_q <= issue_cnt_d;
        end
    end

    // Register file: writeback is independent of the issue handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wb_en) begin
            regs_q[wb_addr] <= wb_data;
        end
    end

    assign ex_valid  = ex_valid_q;
    assign alu_ctrl  = alu_ctrl_q;
    assign inp1      = inp1_q;
    assign inp2      = inp2_q;
    assign ex_rd     = ex_rd_q;
    assign ex_wb_en  = ex_wb_en_q;
    assign issue_cnt = issue_cnt_q;

endmodule

// File: tb/tb_ex_issue_unit.sv
// tb_ex_issue_unit
// Self-checking bench for ex_issue_unit. Directed instructions are sent by
// applyStimulus, which queues the hand-computed ALU-side response; a monitor
// pops and compares each op as execute consumes it.
module tb_ex_issue_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       instr_valid;
    logic [7:0] instr;
    logic       instr_ready;
    logic       wb_en;
    logic [1:0] wb_addr;
    logic [7:0] wb_data;
    logic [7:0] alu_result;
    logic       ex_ready;
    logic       ex_valid;
    logic [1:0] alu_ctrl;
    logic [7:0] inp1;
    logic [7:0] inp2;
    logic [1:0] ex_rd;
    logic       ex_wb_en;
    logic [7:0] issue_cnt;

    typedef struct {
        logic [1:0] ctrl;
        logic [7:0] a;
        logic [7:0] b;
        logic [1:0] rd;
        logic [7:0] cnt;
    } exp_t;

    exp_t       expQ[$];
    exp_t       stallExp;
    int         cmpCount = 0;
    int         errCount = 0;
    logic [7:0] cntModel;

    ex_issue_unit #(.DATA_W(8), .REGS(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_ready (instr_ready),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .alu_result  (alu_result),
        .ex_ready    (ex_ready),
        .ex_valid    (ex_valid),
        .alu_ctrl    (alu_ctrl),
        .inp1        (inp1),
        .inp2        (inp2),
        .ex_rd       (ex_rd),
        .ex_wb_en    (ex_wb_en),
        .issue_cnt   (issue_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        cmpCount++;
        if (actual !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Drive one instruction until accepted; non-NOPs queue their expected issue.
    task automatic applyStimulus(input logic [7:0] ins, input logic [1:0] ctrl,
                                 input logic [7:0] a, input logic [7:0] b);
        bit   accepted;
        exp_t e;
        instr_valid = 1'b1;
        instr       = ins;
        accepted    = 1'b0;
        for (int i = 0; i < 50 && !accepted; i++) begin
            @(negedge clk);
            accepted = instr_ready;
        end
        if (!accepted) begin
            cmpCount++;
            errCount++;
            $display("[TB] FAIL accept_timeout: instr %0h never accepted", ins);
            instr_valid = 1'b0;
        end else begin
            if (ins[7:6] != 2'b00) begin
                cntModel++;
                e.ctrl = ctrl;
                e.a    = a;
                e.b    = b;
                e.rd   = ins[5:4];
                e.cnt  = cntModel;
                expQ.push_back(e);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        instr_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic writeReg(input logic [1:0] addr, input logic [7:0] data);
        wb_en   = 1'b1;
        wb_addr = addr;
        wb_data = data;
        @(posedge clk);
        #1;
        wb_en = 1'b0;
    endtask

    // Monitor: every op taken by execute must match the head of the queue.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && ex_valid && ex_ready) begin
            if (expQ.size() == 0) begin
                cmpCount++;
                errCount++;
                $display("[TB] FAIL unexpected_issue: rd %0d inp1 %0h inp2 %0h with nothing expected",
                         ex_rd, inp1, inp2);
            end else begin
                e = expQ.pop_front();
                checkOutput("alu_ctrl", alu_ctrl, e.ctrl);
                checkOutput("inp1", inp1, e.a);
                checkOutput("inp2", inp2, e.b);
                checkOutput("ex_rd", ex_rd, e.rd);
                checkOutput("ex_wb_en", ex_wb_en, 1);
                checkOutput("issue_cnt", issue_cnt, e.cnt);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        instr       = 8'h00;
        wb_en       = 1'b0;
        wb_addr     = 2'b00;
        wb_data     = 8'h00;
        alu_result  = 8'h00;
        ex_ready    = 1'b1;
        cntModel    = 8'd0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_ex_valid", ex_valid, 0);
        checkOutput("rst_alu_ctrl", alu_ctrl, 0);
        checkOutput("rst_inp1", inp1, 0);
        checkOutput("rst_inp2", inp2, 0);
        checkOutput("rst_ex_rd", ex_rd, 0);
        checkOutput("rst_ex_wb_en", ex_wb_en, 0);
        checkOutput("rst_issue_cnt", issue_cnt, 0);
        checkOutput("rst_instr_ready", instr_ready, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1);

        // MOVI r1,5 then SLL r1,r1 back-to-back: SLL takes r1 from EX.
        applyStimulus(8'h95, 2'b11, 8'h00, 8'h05);
        alu_result = 8'h05;
        applyStimulus(8'h54, 2'b01, 8'h05, 8'h05);
        idle(2);
        alu_result = 8'hEE;

        // Register reads after writeback.
        writeReg(2'd1, 8'h05);
        writeReg(2'd2, 8'h03);
        applyStimulus(8'hD8, 2'b11, 8'h05, 8'h03);
        idle(2);

        // WB bypass in the accept cycle, then the written register itself.
        wb_en   = 1'b1;
        wb_addr = 2'd0;
        wb_data = 8'h09;
        applyStimulus(8'hE0, 2'b11, 8'h03, 8'h09);
        wb_en = 1'b0;
        idle(2);
        applyStimulus(8'hC0, 2'b11, 8'h09, 8'h09);
        idle(2);

        // EX and WB both target r3: EX wins, but the write still lands.
        applyStimulus(8'hB7, 2'b11, 8'h00, 8'h07);
        alu_result = 8'h21;
        wb_en      = 1'b1;
        wb_addr    = 2'd3;
        wb_data    = 8'h44;
        applyStimulus(8'hFC, 2'b11, 8'h21, 8'h21);
        wb_en = 1'b0;
        idle(2);
        alu_result = 8'hEE;
        applyStimulus(8'hF8, 2'b11, 8'h44, 8'h03);
        idle(2);

        // Stall: op held for three cycles, next one issues after ex_ready.
        ex_ready = 1'b0;
        applyStimulus(8'hAA, 2'b11, 8'h00, 8'h0A);
        instr       = 8'hE8;
        instr_valid = 1'b1;
        alu_result  = 8'h0A;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput("stall_instr_ready", instr_ready, 0);
            checkOutput("stall_ex_valid", ex_valid, 1);
            checkOutput("stall_alu_ctrl", alu_ctrl, 2'b11);
            checkOutput("stall_inp1", inp1, 8'h00);
            checkOutput("stall_inp2", inp2, 8'h0A);
            checkOutput("stall_ex_rd", ex_rd, 2);
        end
        @(posedge clk);
        #1;
        ex_ready = 1'b1;
        cntModel++;
        stallExp.ctrl = 2'b11;
        stallExp.a    = 8'h0A;
        stallExp.b    = 8'h0A;
        stallExp.rd   = 2'd2;
        stallExp.cnt  = cntModel;
        expQ.push_back(stallExp);
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        @(negedge clk);
        checkOutput("issue_after_stall", ex_valid, 1);
        idle(2);
        alu_result = 8'hEE;

        // NOP right behind a MOVI becomes a bubble.
        applyStimulus(8'h81, 2'b11, 8'h00, 8'h01);
        applyStimulus(8'h00, 2'b00, 8'h00, 8'h00);
        instr_valid = 1'b0;
        @(negedge clk);
        checkOutput("nop_bubble", ex_valid, 0);
        checkOutput("nop_issue_cnt", issue_cnt, cntModel);
        idle(1);

        // Enough MOVIs to bring the issue counter round to zero.
        begin
            int n;
            n = 256 - int'(cntModel);
            for (int i = 0; i < n; i++) begin
                logic [3:0] im;
                im = i[3:0];
                applyStimulus({4'b1001, im}, 2'b11, 8'h00, {4'h0, im});
            end
        end
        instr_valid = 1'b0;
        @(negedge clk);
        checkOutput("issue_cnt_wrap", issue_cnt, 0);
        idle(2);

        // Asynchronous reset while an op is held and a write is pending.
        ex_ready = 1'b0;
        applyStimulus(8'hBF, 2'b11, 8'h00, 8'h0F);
        instr_valid = 1'b0;
        wb_en       = 1'b1;
        wb_addr     = 2'd1;
        wb_data     = 8'h77;
        @(negedge clk);
        checkOutput("held_before_reset", ex_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_ex_valid", ex_valid, 0);
        checkOutput("async_rst_ex_wb_en", ex_wb_en, 0);
        checkOutput("async_rst_alu_ctrl", alu_ctrl, 0);
        checkOutput("async_rst_inp2", inp2, 0);
        checkOutput("async_rst_issue_cnt", issue_cnt, 0);
        expQ.delete();
        cntModel = 8'd0;
        wb_en    = 1'b0;
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        ex_ready = 1'b1;
        idle(1);
        applyStimulus(8'hC4, 2'b11, 8'h00, 8'h00);
        applyStimulus(8'hEC, 2'b11, 8'h00, 8'h00);
        idle(3);

        checkOutput("queue_drained", expQ.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
        $finish;
    end

endmodule
